// File: rtl/dma_scheduler_pkg.sv
// dma_sched_pkg: shared state encoding and width helper for the DMA scheduler
package dma_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dma_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting just after the last winner
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    int j;

    // first high request at offsets 1..N from the last winner, wrapping
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        j       = 0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(last_i) + k) % N;
            if (!valid_o && req_i[j]) begin
                valid_o    = 1'b1;
                idx_o      = IW'(j);
                grant_o[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_scheduler.sv
// dma_scheduler: round-robin sharing of one DMA burst-read engine between requesters
module dma_scheduler
    import dma_sched_pkg::*;
#(
    parameter int NUM_REQ           = 2,
    parameter int MEM_ADDRESS_WIDTH = 10,
    parameter int COUNT_WIDTH       = 16,
    parameter int BUFFER_SIZE       = 20,
    parameter int TIMEOUT_CYCLES    = 1024
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_REQ-1:0]                     i_req,
    input  logic [NUM_REQ*MEM_ADDRESS_WIDTH-1:0]   i_req_address,
    input  logic [NUM_REQ*COUNT_WIDTH-1:0]         i_req_count,
    output logic [NUM_REQ-1:0]                     o_grant,
    output logic [NUM_REQ-1:0]                     o_done,
    output logic                                   o_err,
    output logic                                   o_busy,
    output logic                                   o_dma_read,
    output logic [MEM_ADDRESS_WIDTH-1:0]           o_dma_address,
    output logic [COUNT_WIDTH-1:0]                 o_dma_count,
    input  logic                                   i_dma_ready
);

    localparam int IW = idx_width(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    state_e                         state_q, state_d;
    logic [IW-1:0]                  win_q, win_d;
    logic [IW-1:0]                  last_q, last_d;
    logic [NUM_REQ-1:0]             grant_q, grant_d;
    logic                           err_q, err_d;
    logic [MEM_ADDRESS_WIDTH-1:0]   addr_q, addr_d;
    logic [COUNT_WIDTH-1:0]         cnt_q, cnt_d;
    logic [TW-1:0]                  timer_q, timer_d;

    logic [NUM_REQ-1:0]             arb_grant;
    logic [IW-1:0]                  arb_idx;
    logic                           arb_valid;
    logic [MEM_ADDRESS_WIDTH-1:0]   sel_addr;
    logic [COUNT_WIDTH-1:0]         sel_cnt;
    logic                           sel_zero;
    logic                           sel_big;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_arb (
        .req_i   (i_req),
        .last_i  (last_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    assign sel_addr = i_req_address[arb_idx*MEM_ADDRESS_WIDTH +: MEM_ADDRESS_WIDTH];
    assign sel_cnt  = i_req_count[arb_idx*COUNT_WIDTH +: COUNT_WIDTH];
    assign sel_zero = (sel_cnt == '0);
    assign sel_big  = (sel_cnt > COUNT_WIDTH'(BUFFER_SIZE));

    // next state: arbitrate and screen in IDLE, pulse start in ISSUE, watchdog in WAIT
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        last_d  = last_q;
        grant_d = grant_q;
        err_d   = err_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    win_d   = arb_idx;
                    grant_d = arb_grant;
                    addr_d  = sel_addr;
                    cnt_d   = sel_cnt;
                    err_d   = sel_big;
                    state_d = (sel_zero || sel_big) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (i_dma_ready) begin
                    state_d = DONE;
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DONE: begin
                last_d  = win_q;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers; reset makes requester 0 the first choice
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            win_q   <= '0;
            last_q  <= IW'(NUM_REQ - 1);
            grant_q <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
        end
    end

    assign o_busy        = (state_q != IDLE);
    assign o_grant       = o_busy ? grant_q : '0;
    assign o_done        = (state_q == DONE) ? grant_q : '0;
    assign o_err         = (state_q == DONE) && err_q;
    assign o_dma_read    = (state_q == ISSUE);
    assign o_dma_address = addr_q;
    assign o_dma_count   = cnt_q;

endmodule

// File: tb/tb_dma_scheduler.sv
// tb_dma_scheduler: directed and randomized checks of dma_scheduler against a transaction-level model
module tb_dma_scheduler;

    localparam int NR  = 2;
    localparam int AW  = 10;
    localparam int CW  = 16;
    localparam int BUF = 20;
    localparam int TO  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     i_req = '0;
    logic [NR*AW-1:0]  i_req_address = '0;
    logic [NR*CW-1:0]  i_req_count = '0;
    logic              i_dma_ready = 1'b0;
    logic [NR-1:0]     o_grant;
    logic [NR-1:0]     o_done;
    logic              o_err;
    logic              o_busy;
    logic              o_dma_read;
    logic [AW-1:0]     o_dma_address;
    logic [CW-1:0]     o_dma_count;

    dma_scheduler #(
        .NUM_REQ           (NR),
        .MEM_ADDRESS_WIDTH (AW),
        .COUNT_WIDTH       (CW),
        .BUFFER_SIZE       (BUF),
        .TIMEOUT_CYCLES    (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_req         (i_req),
        .i_req_address (i_req_address),
        .i_req_count   (i_req_count),
        .o_grant       (o_grant),
        .o_done        (o_done),
        .o_err         (o_err),
        .o_busy        (o_busy),
        .o_dma_read    (o_dma_read),
        .o_dma_address (o_dma_address),
        .o_dma_count   (o_dma_count),
        .i_dma_ready   (i_dma_ready)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    always @(posedge clk) cyc <= cyc + 1;

    int          n_read   = 0;
    int          n_done   = 0;
    int          rd_cyc   = 0;
    int          done_cyc = 0;
    int          rdy_cyc  = 0;
    int          done_who = 0;
    logic        done_err = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [CW-1:0] rd_cnt  = '0;
    int          gq[$];

    int          eng_delay = 0;
    int          pend      = 0;
    bit          eng_kick  = 0;
    bit          rnd_en    = 0;
    bit [NR-1:0] hold      = '0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_dones(input int target, input int budget);
        for (int b = 0; b < budget && n_done < target; b++) tick();
        if (n_done < target) chk("done_wait", 64'(n_done), 64'(target));
    endtask

    function automatic logic [CW-1:0] rand_cnt();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return CW'(BUF + 1);
            2: return CW'(BUF);
            3: return CW'($urandom);
            default: return CW'($urandom_range(1, BUF));
        endcase
    endfunction

    // engine: ready a set delay after each start, plus optional kick and noise
    initial forever begin
        @(posedge clk);
        #1;
        i_dma_ready = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) i_dma_ready = 1'b1;
        end
        if (o_dma_read)
            pend = rnd_en ? (($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 12))) : eng_delay;
        if (eng_kick) begin
            i_dma_ready = 1'b1;
            eng_kick = 0;
        end
        if (rnd_en && $urandom_range(0, 15) == 0) i_dma_ready = 1'b1;
    end

    // requesters: drop on own done, random raises and mid-transaction drops
    initial forever begin
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (i_req[i] && o_done[i] && !hold[i] && !(rnd_en && $urandom_range(0, 3) == 0))
                i_req[i] = 1'b0;
            else if (rnd_en && i_req[i] && o_grant[i] && !o_done[i] && $urandom_range(0, 31) == 0)
                i_req[i] = 1'b0;
            else if (rnd_en && !i_req[i] && $urandom_range(0, 3) == 0) begin
                i_req_address[i*AW +: AW] = AW'($urandom);
                i_req_count[i*CW +: CW]   = rand_cnt();
                i_req[i] = 1'b1;
            end
        end
    end

    // model: a transaction is an owner plus the age at which its done falls
    initial begin : cmp
        bit            m_valid, m_on, m_legal, m_err;
        int            m_own, m_last, m_age, m_done_at, j;
        logic [AW-1:0] m_addr;
        logic [CW-1:0] m_cnt;
        logic [NR-1:0] e_grant, e_done;
        logic          e_err, e_read;
        m_valid = 0; m_on = 0; m_legal = 0; m_err = 0;
        m_own = 0; m_last = NR - 1; m_age = 0; m_done_at = 0; j = 0;
        m_addr = '0; m_cnt = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_valid = 1; m_on = 0; m_last = NR - 1; m_addr = '0; m_cnt = '0;
            end else if (m_valid) begin
                if (!m_on) begin
                    for (int k = 1; k <= NR; k++) begin
                        j = (m_last + k) % NR;
                        if (!m_on && i_req[j]) begin
                            m_on = 1;
                            m_own = j;
                        end
                    end
                    if (m_on) begin
                        m_addr    = i_req_address[m_own*AW +: AW];
                        m_cnt     = i_req_count[m_own*CW +: CW];
                        m_legal   = (m_cnt != 0) && (m_cnt <= BUF);
                        m_err     = (m_cnt > BUF);
                        m_age     = 1;
                        m_done_at = m_legal ? 0 : 1;
                    end
                end else if (m_age == m_done_at) begin
                    m_on = 0;
                    m_last = m_own;
                end else begin
                    if (m_legal && m_age >= 2 && m_done_at == 0) begin
                        if (i_dma_ready) m_done_at = m_age + 1;
                        else if (m_age == TO + 1) begin
                            m_err = 1;
                            m_done_at = m_age + 1;
                        end
                    end
                    m_age++;
                end
            end
            @(negedge clk);
            if (m_valid) begin
                e_grant = m_on ? (NR'(1) << m_own) : '0;
                e_done  = (m_on && m_age == m_done_at) ? e_grant : '0;
                e_err   = (|e_done) && m_err;
                e_read  = m_on && m_legal && (m_age == 1);
                compared++;
                if ({o_grant, o_done, o_err, o_busy, o_dma_read, o_dma_address, o_dma_count} !==
                    {e_grant, e_done, e_err, m_on, e_read, m_addr, m_cnt}) begin
                    mismatched++;
                    $display("FAIL cycle %0d: got grant=%b done=%b err=%b busy=%b read=%b addr=%h cnt=%h, expected grant=%b done=%b err=%b busy=%b read=%b addr=%h cnt=%h",
                             cyc, o_grant, o_done, o_err, o_busy, o_dma_read, o_dma_address, o_dma_count,
                             e_grant, e_done, e_err, m_on, e_read, m_addr, m_cnt);
                end
            end
            if (o_dma_read === 1'b1) begin
                n_read++; rd_addr = o_dma_address; rd_cnt = o_dma_count; rd_cyc = cyc;
            end
            if (|o_done) begin
                for (int i = 0; i < NR; i++) if (o_done[i]) done_who = i;
                n_done++; done_err = o_err; done_cyc = cyc;
                gq.push_back(done_who);
            end
            if (i_dma_ready) rdy_cyc = cyc;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int r, n0, nd;
        repeat (3) tick();
        chk("rst_busy", 64'(o_busy), 64'(0));
        chk("rst_grant", 64'(o_grant), 64'(0));
        chk("rst_addr", 64'(o_dma_address), 64'(0));
        rst = 1'b0;
        tick();

        r = cyc; n0 = n_read; eng_delay = 10;
        i_req_address[0 +: AW] = 10'h040; i_req_count[0 +: CW] = 16'd8; i_req[0] = 1'b1;
        wait_dones(n_done + 1, 40);
        chk("single_reads", 64'(n_read - n0), 64'(1));
        chk("single_addr", 64'(rd_addr), 64'h040);
        chk("single_cnt", 64'(rd_cnt), 64'd8);
        chk("single_read_cyc", 64'(rd_cyc), 64'(r + 1));
        chk("single_done_cyc", 64'(done_cyc), 64'(rd_cyc + 11));
        chk("single_done_after_ready", 64'(done_cyc - rdy_cyc), 64'(1));
        chk("single_who", 64'(done_who), 64'(0));
        chk("single_err", 64'(done_err), 64'(0));

        rst = 1'b1; tick(); rst = 1'b0; tick();
        gq.delete(); eng_delay = 3; hold = 2'b11;
        i_req_address = {10'h111, 10'h022}; i_req_count = {16'd5, 16'd4}; i_req = 2'b11;
        wait_dones(n_done + 4, 100);
        i_req = '0; hold = '0;
        if (gq.size() >= 4) begin
            chk("fair_0", 64'(gq[0]), 64'(0));
            chk("fair_1", 64'(gq[1]), 64'(1));
            chk("fair_2", 64'(gq[2]), 64'(0));
            chk("fair_3", 64'(gq[3]), 64'(1));
        end else chk("fair_count", 64'(gq.size()), 64'(4));

        tick();
        r = cyc; n0 = n_read;
        i_req_count[CW +: CW] = '0; i_req[1] = 1'b1;
        wait_dones(n_done + 1, 10);
        chk("zero_done_cyc", 64'(done_cyc), 64'(r + 1));
        chk("zero_who", 64'(done_who), 64'(1));
        chk("zero_err", 64'(done_err), 64'(0));
        chk("zero_reads", 64'(n_read), 64'(n0));

        tick();
        r = cyc; n0 = n_read; eng_delay = 2;
        i_req_address = {10'h200, 10'h100}; i_req_count = {16'd4, 16'd21}; i_req = 2'b11;
        wait_dones(n_done + 1, 10);
        chk("big_done_cyc", 64'(done_cyc), 64'(r + 1));
        chk("big_who", 64'(done_who), 64'(0));
        chk("big_err", 64'(done_err), 64'(1));
        chk("big_reads", 64'(n_read), 64'(n0));
        wait_dones(n_done + 1, 30);
        chk("next_who", 64'(done_who), 64'(1));
        chk("next_err", 64'(done_err), 64'(0));
        chk("next_reads", 64'(n_read), 64'(n0 + 1));
        chk("next_addr", 64'(rd_addr), 64'h200);

        tick();
        n0 = n_read; eng_delay = 0;
        i_req_count[0 +: CW] = 16'd5; i_req[0] = 1'b1;
        wait_dones(n_done + 1, 40);
        chk("to_err", 64'(done_err), 64'(1));
        chk("to_who", 64'(done_who), 64'(0));
        chk("to_latency", 64'(done_cyc - rd_cyc), 64'(TO + 1));
        chk("to_reads", 64'(n_read), 64'(n0 + 1));
        eng_kick = 1; nd = n_done;
        repeat (4) tick();
        chk("late_ready_done", 64'(n_done), 64'(nd));
        chk("late_ready_busy", 64'(o_busy), 64'(0));

        eng_delay = 6; r = cyc;
        i_req_address[0 +: AW] = 10'h3FF; i_req_count[0 +: CW] = 16'd3; i_req[0] = 1'b1;
        repeat (4) tick();
        chk("midwait_busy", 64'(o_busy), 64'(1));
        nd = n_done;
        rst = 1'b1; i_req[0] = 1'b0;
        tick();
        chk("rstwait_busy", 64'(o_busy), 64'(0));
        chk("rstwait_grant", 64'(o_grant), 64'(0));
        chk("rstwait_addr", 64'(o_dma_address), 64'(0));
        chk("rstwait_cnt", 64'(o_dma_count), 64'(0));
        rst = 1'b0;
        repeat (4) tick();
        chk("rstwait_nodone", 64'(n_done), 64'(nd));
        eng_delay = 2;
        i_req_address[0 +: AW] = 10'h055; i_req_count[0 +: CW] = 16'd7; i_req[0] = 1'b1;
        wait_dones(n_done + 1, 20);
        chk("after_rst_who", 64'(done_who), 64'(0));
        chk("after_rst_err", 64'(done_err), 64'(0));
        chk("after_rst_addr", 64'(rd_addr), 64'h055);

        tick();
        rnd_en = 1;
        repeat (3000) begin
            tick();
            rst = ($urandom_range(0, 299) == 0);
        end
        rnd_en = 0; rst = 1'b0; i_req = '0;
        repeat (40) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
